// File: rtl/maze_mem_arbiter.sv
// Two-requester arbiter for the maze memory: solver datapath vs. host loader, with host locking.
// Define MAZE_ARB_RR_EN for round-robin ties; otherwise the host has fixed priority over the solver.
module maze_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sol_req,
  input  logic              sol_we,
  input  logic [ADDR_W-1:0] sol_addr,
  input  logic [DATA_W-1:0] sol_wdata,
  output logic              sol_gnt,
  output logic              sol_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {OPEN, LOCKED} state_t;

  state_t state, state_nxt;
  logic   sol_elig, host_elig;
  logic   sol_win, host_win;
  logic   rd_valid, rd_owner;

`ifdef MAZE_ARB_RR_EN
  logic last_host;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_host <= 1'b1;
    else if (sol_win || host_win)
      last_host <= host_win;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= OPEN;
    else
      state <= state_nxt;
  end

  // Current gnt masks eligibility so a requester dropping req in response is not issued twice.
  always_comb begin
    state_nxt = state;
    sol_elig  = 1'b0;
    host_elig = 1'b0;
    sol_win   = 1'b0;
    host_win  = 1'b0;
    state_nxt = host_lock ? LOCKED : OPEN;
    sol_elig  = sol_req && !sol_gnt && (state == OPEN) && !host_lock;
    host_elig = host_req && !host_gnt;
`ifdef MAZE_ARB_RR_EN
    if (sol_elig && host_elig) begin
      sol_win  = last_host;
      host_win = !last_host;
    end else begin
      sol_win  = sol_elig;
      host_win = host_elig;
    end
`else
    // A pending host request blocks the solver even in the host's masked cycle.
    host_win = host_elig;
    sol_win  = sol_elig && !host_req;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sol_gnt   <= 1'b0;
      host_gnt  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_owner  <= 1'b0;
    end else begin
      mem_en   <= sol_win || host_win;
      sol_gnt  <= sol_win;
      host_gnt <= host_win;
      if (host_win) begin
        mem_we    <= host_we;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end else if (sol_win) begin
        mem_we    <= sol_we;
        mem_addr  <= sol_addr;
        mem_wdata <= sol_wdata;
      end else begin
        mem_we    <= 1'b0;
      end
      // Record the read issued this cycle; its data returns next cycle.
      rd_valid <= mem_en && !mem_we;
      rd_owner <= host_gnt;
    end
  end

  assign sol_rvalid  = rd_valid && !rd_owner;
  assign host_rvalid = rd_valid && rd_owner;
  assign rdata       = rd_valid ? mem_rdata : '0;
  assign locked      = (state == LOCKED);

endmodule
